// File: rtl/core_mem_mmio_bridge.sv
// rtl/core_mem_mmio_bridge.sv - word RAM plus console FIFO, cycle counter and halt MMIO behind the core memory port
module core_mem_mmio_bridge #(
    parameter int RAM_WORDS = 4096,
    parameter     INIT_FILE = "",
    parameter int TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] core_address,
    input  logic [31:0] core_wdata,
    input  logic        core_we,
    output logic [31:0] core_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        bus_err
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    last_byte;
    logic [31:0]   cycle_cnt;
    logic [31:0]   rd_mux;

    logic          is_ram, is_mmio, ram_wr, mmio_wr, push, pop, push_ok, full, empty;
    logic [1:0]    reg_sel;
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    assign is_ram   = (core_address[31:28] == 4'h0);
    assign is_mmio  = (core_address[31:4] == 28'h8000000);
    assign reg_sel  = core_address[3:2];
    assign idx      = core_address[AW+1:2];
    assign unused_addr_bits = ^core_address[1:0];

    // Writes are gated by reset so a write presented during reset leaves no trace.
    assign ram_wr   = resetn && core_we && is_ram;
    assign mmio_wr  = resetn && core_we && is_mmio;

    assign full     = (count == CW'(TX_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo[rptr];
    assign pop      = tx_valid && tx_ready;
    assign push     = mmio_wr && (reg_sel == 2'd0);
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (ram_wr) ram[idx] <= core_wdata;
        if (push_ok) fifo[wptr] <= core_wdata[7:0];
    end

    always_comb begin
        rd_mux = 32'h0;
        if (is_ram) begin
            rd_mux = ram[idx];
        end else if (is_mmio) begin
            case (reg_sel)
                2'd0:    rd_mux = {24'h0, last_byte};
                2'd1:    rd_mux = {29'h0, overflow, full, empty};
                2'd2:    rd_mux = cycle_cnt;
                default: rd_mux = {31'h0, halt};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            core_rdata <= 32'h0;
            bus_err    <= 1'b0;
            cycle_cnt  <= 32'h0;
            halt       <= 1'b0;
            halt_code  <= 32'h0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            last_byte  <= 8'h0;
        end else begin
            if (!core_we) core_rdata <= rd_mux;
            bus_err <= !is_ram && !is_mmio;

            // A load reads back as wdata+1 on the following cycle, as if it had already ticked.
            if (mmio_wr && reg_sel == 2'd2) cycle_cnt <= core_wdata + 32'd1;
            else                            cycle_cnt <= cycle_cnt + 32'd1;

            if (mmio_wr && reg_sel == 2'd3 && !halt) begin
                halt      <= 1'b1;
                halt_code <= core_wdata;
            end

            if (mmio_wr && reg_sel == 2'd1 && core_wdata[2]) overflow <= 1'b0;
            else if (push && !push_ok)                       overflow <= 1'b1;

            if (push_ok) begin
                wptr      <= wptr + PW'(1);
                last_byte <= core_wdata[7:0];
            end
            if (pop) rptr <= rptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
